// File: rtl/mem_data_ctrl.sv
// MEM-stage data memory with req/resp handshake, B/H/W access and wait states.
// Define MEM_DATA_ALIGN_CHECK_EN to fault misaligned half/word accesses.
module mem_data_ctrl #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int ADDRESSLEN  = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDRESSLEN-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;

  logic                  lat_write;
  logic [2:0]            lat_size;
  logic [ADDRESSLEN-1:0] lat_addr;
  logic [XLEN-1:0]       lat_wdata;

  logic                  op_write;
  logic [2:0]            op_size;
  logic [ADDRESSLEN-1:0] op_addr;
  logic [XLEN-1:0]       op_wdata;

  logic [XLEN-1:0] mem [DEPTH];

  logic            hs;
  logic            enter_resp;
  logic [AW-1:0]   word_idx;
  logic            oor, size_bad, st_bad, mis, err;
  logic [XLEN-1:0] rd_word, load_data, new_word, wval;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [3:0]      wmask;
  logic            we;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign hs         = req_valid & req_ready;

  // With zero wait states the access resolves on the accept edge itself.
  assign op_write = (state == IDLE) ? req_write : lat_write;
  assign op_size  = (state == IDLE) ? req_size  : lat_size;
  assign op_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign op_wdata = (state == IDLE) ? req_wdata : lat_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (hs) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
          end else begin
            state_nx = BUSY;
            cnt_nx   = 8'(WAIT_CYCLES - 1);
          end
        end
      end
      BUSY: begin
        if (cnt == 8'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 8'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_resp = (state_nx == RESP) && (state != RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (hs) begin
      lat_write <= req_write;
      lat_size  <= req_size;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  assign word_idx = op_addr[AW+1:2];
  assign oor      = |op_addr[ADDRESSLEN-1:AW+2];
  assign size_bad = (op_size == 3'b011) | (op_size[2:1] == 2'b11);
  assign st_bad   = op_write & op_size[2];

`ifdef MEM_DATA_ALIGN_CHECK_EN
  assign mis = ((op_size[1:0] == 2'b01) & op_addr[0])
             | ((op_size[1:0] == 2'b10) & (|op_addr[1:0]));
`else
  assign mis = 1'b0;
`endif

  assign err = oor | size_bad | st_bad | mis;

  assign rd_word = mem[word_idx];
  assign byte_v  = rd_word[{op_addr[1:0], 3'b000} +: 8];
  assign half_v  = rd_word[{op_addr[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    case (op_size)
      3'b000:  load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b001:  load_data = {{(XLEN-16){half_v[15]}}, half_v};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_v};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, half_v};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    wmask = 4'b0000;
    wval  = op_wdata;
    case (op_size[1:0])
      2'b00: begin
        wmask = 4'b0001 << op_addr[1:0];
        wval  = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        wmask = 4'b0011 << {op_addr[1], 1'b0};
        wval  = {2{op_wdata[15:0]}};
      end
      2'b10:   wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
  end

  always_comb begin
    new_word = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (wmask[i]) new_word[8*i +: 8] = wval[8*i +: 8];
    end
  end

  assign we = enter_resp & op_write & ~err & rst_n;

  always_ff @(posedge clk) begin
    if (we) mem[word_idx] <= new_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= err;
      resp_rdata <= (err | op_write) ? '0 : load_data;
    end
  end

endmodule
